// File: rtl/universal_shift_reg_param.sv
// WIDTH-bit universal shift register. It supports direct hold, shift, rotate, load and clear operations,
// plus a counted burst-shift engine with a busy/done handshake.
module universal_shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             sr,
  input  logic             sl,
  input  logic [CNT_W-1:0] amt,
  input  logic             start,
  output logic [WIDTH-1:0] q_out,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nextQ;
  logic [WIDTH-1:0] w_opQ;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [2:0]       r_mode;
  logic [2:0]       w_nextMode;
  logic [2:0]       w_opMode;
  logic             w_shiftReq;

  always_ff @(posedge i_clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_nextState;
      r_q     <= w_nextQ;
      r_cnt   <= w_nextCnt;
      r_mode  <= w_nextMode;
    end
  end

  // While a burst runs, the latched mode drives the datapath and the live mode is ignored.
  always_comb begin
    w_opMode = (r_state == BURST) ? r_mode : mode;
    w_opQ    = r_q;
    case (w_opMode)
      3'b000:  w_opQ = r_q;
      3'b001:  w_opQ = {sr, r_q[WIDTH-1:1]};
      3'b010:  w_opQ = {r_q[WIDTH-2:0], sl};
      3'b011:  w_opQ = in;
      3'b100:  w_opQ = {r_q[0], r_q[WIDTH-1:1]};
      3'b101:  w_opQ = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      3'b110:  w_opQ = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      default: w_opQ = '0;
    endcase
  end

  always_comb begin
    w_shiftReq  = start && (mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110});
    w_nextState = r_state;
    w_nextQ     = r_q;
    w_nextCnt   = r_cnt;
    w_nextMode  = r_mode;
    case (r_state)
      BURST: begin
        if (en) begin
          w_nextQ   = w_opQ;
          w_nextCnt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_nextState = DONE;
          end
        end
      end
      default: begin
        // DONE accepts new work exactly like IDLE; a burst start ignores en.
        w_nextState = IDLE;
        if (w_shiftReq) begin
          w_nextMode = mode;
          if (amt != '0) begin
            w_nextCnt   = amt;
            w_nextState = BURST;
          end else begin
            w_nextState = DONE;
          end
        end else if (en) begin
          w_nextQ = w_opQ;
        end
      end
    endcase
  end

  assign q_out = r_q;
  assign so_r  = r_q[0];
  assign so_l  = r_q[WIDTH-1];
  assign busy  = (r_state == BURST);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_universal_shift_reg_param.sv
// Self-checking bench for universal_shift_reg_param: a scoreboard fed by a behavioural model,
// plus directed checks on known register values.
`timescale 1ns/1ps
module tb_universal_shift_reg_param;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int MASK = (1 << W) - 1;

  logic          i_clk = 1'b0;
  logic          clr   = 1'b0;
  logic          en    = 1'b0;
  logic [2:0]    mode  = '0;
  logic [W-1:0]  tbIn  = '0;
  logic          sr    = 1'b0;
  logic          sl    = 1'b0;
  logic [CW-1:0] amt   = '0;
  logic          start = 1'b0;
  logic [W-1:0]  q_out;
  logic          so_r;
  logic          so_l;
  logic          busy;
  logic          done;

  universal_shift_reg_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk(i_clk), .clr(clr), .en(en), .mode(mode), .in(tbIn), .sr(sr), .sl(sl),
    .amt(amt), .start(start), .q_out(q_out), .so_r(so_r), .so_l(so_l),
    .busy(busy), .done(done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int q;
    int busy;
    int done;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Reference model: register value, shifts still owed, the latched operation and a done flag.
  int   mQ         = 0;
  int   mRemaining = 0;
  int   mOp        = 0;
  int   mDone      = 0;

  task automatic compare(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int opModel(int m, int q, int s_r, int s_l, int d);
    case (m)
      0:       return q;
      1:       return (q >> 1) | (s_r << (W - 1));
      2:       return ((q << 1) | s_l) & MASK;
      3:       return d & MASK;
      4:       return (q >> 1) | ((q & 1) << (W - 1));
      5:       return ((q << 1) & MASK) | (q >> (W - 1));
      6:       return (q >> 1) | (q & (1 << (W - 1)));
      default: return 0;
    endcase
  endfunction

  function automatic bit isShiftMode(int m);
    return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
  endfunction

  task automatic modelStep(input int e, input int m, input int d, input int s_r, input int s_l,
                           input int a, input int st);
    int newDone;
    newDone = 0;
    if (mRemaining > 0) begin
      if (e != 0) begin
        mQ = opModel(mOp, mQ, s_r, s_l, d);
        mRemaining--;
        if (mRemaining == 0) newDone = 1;
      end
    end else if ((st != 0) && isShiftMode(m)) begin
      mOp        = m;
      mRemaining = a;
      if (a == 0) newDone = 1;
    end else if (e != 0) begin
      mQ = opModel(m, mQ, s_r, s_l, d);
    end
    mDone = newDone;
  endtask

  // Drives one cycle of inputs at the falling edge and queues the response due after the next rising edge.
  task automatic applyStimulus(input int e, input int m, input int d, input int s_r, input int s_l,
                               input int a, input int st);
    exp_t x;
    @(negedge i_clk);
    en    = e[0];
    mode  = m[2:0];
    tbIn  = d[W-1:0];
    sr    = s_r[0];
    sl    = s_l[0];
    amt   = a[CW-1:0];
    start = st[0];
    modelStep(e, m, d, s_r, s_l, a, st);
    x.q    = mQ;
    x.busy = (mRemaining > 0) ? 1 : 0;
    x.done = mDone;
    expQ.push_back(x);
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int d);
    applyStimulus(1, 3, d, 0, 0, 0, 0);
  endtask

  // Directed check against a known constant, taken two time units after the next rising edge.
  task automatic checkOutput(input string name, input int q, input int b, input int dn);
    @(posedge i_clk);
    #2;
    compare(name, {q_out, busy, done}, {q[W-1:0], b[0], dn[0]});
  endtask

  task automatic resetPulse(input string name);
    #1 clr = 1'b0;
    #1;
    compare(name, {q_out, busy, done}, 10'h000);
    mQ         = 0;
    mRemaining = 0;
    mDone      = 0;
    clr        = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        compare("sbQ",    q_out, e.q);
        compare("sbBusy", busy,  e.busy);
        compare("sbDone", done,  e.done);
        compare("sbSoR",  so_r,  e.q & 1);
        compare("sbSoL",  so_l,  (e.q >> (W - 1)) & 1);
      end
    end
  end

  initial begin : stimulus
    #1;
    compare("resetInit", {q_out, so_r, so_l, busy, done}, 12'h000);
    #2 clr = 1'b1;

    $display("[TB] direct operations");
    load(8'hA5);                     checkOutput("loadA5", 8'hA5, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0); checkOutput("shr",  8'hD2, 0, 0);
    applyStimulus(1, 2, 0, 0, 0, 0, 0); checkOutput("shl",  8'hA4, 0, 0);
    idle();                          checkOutput("hold",  8'hA4, 0, 0);
    applyStimulus(1, 7, 0, 0, 0, 0, 0); checkOutput("clear", 8'h00, 0, 0);

    $display("[TB] asynchronous reset");
    load(8'h5A);                     checkOutput("load5A", 8'h5A, 0, 0);
    resetPulse("asyncReset");

    $display("[TB] rotate burst");
    load(8'h81);
    applyStimulus(1, 4, 0, 0, 0, 3, 1); checkOutput("rotStart", 8'h81, 1, 0);
    idle();                          checkOutput("rot1", 8'hC0, 1, 0);
    idle();                          checkOutput("rot2", 8'h60, 1, 0);
    idle();                          checkOutput("rot3", 8'h30, 0, 1);
    compare("rotSoR", so_r, 0);
    idle();                          checkOutput("rotAfter", 8'h30, 0, 0);

    $display("[TB] arithmetic shift burst");
    load(8'h90);
    applyStimulus(1, 6, 0, 0, 0, 2, 1); checkOutput("asrStart", 8'h90, 1, 0);
    idle();                          checkOutput("asr1", 8'hC8, 1, 0);
    idle();                          checkOutput("asr2", 8'hE4, 0, 1);

    $display("[TB] stalled burst");
    load(8'h01);
    applyStimulus(1, 2, 0, 0, 0, 4, 1); checkOutput("stallStart", 8'h01, 1, 0);
    idle();                          checkOutput("stall1", 8'h02, 1, 0);
    idle();                          checkOutput("stall2", 8'h04, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("stallHold1", 8'h04, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0); checkOutput("stallHold2", 8'h04, 1, 0);
    idle();                          checkOutput("stall3", 8'h08, 1, 0);
    idle();                          checkOutput("stall4", 8'h10, 0, 1);

    $display("[TB] corner events");
    load(8'h3C);
    applyStimulus(1, 1, 0, 1, 0, 0, 1); checkOutput("amt0Done", 8'h3C, 0, 1);
    idle();                          checkOutput("amt0After", 8'h3C, 0, 0);
    load(8'h0F);
    applyStimulus(1, 5, 0, 0, 0, 2, 1); checkOutput("dropStart", 8'h0F, 1, 0);
    applyStimulus(1, 3, 8'hFF, 0, 0, 1, 1); checkOutput("dropIgnored", 8'h1E, 1, 0);
    idle();                          checkOutput("dropDone", 8'h3C, 0, 1);
    load(8'h40);
    applyStimulus(0, 1, 0, 0, 0, 1, 1); checkOutput("enLowStart", 8'h40, 1, 0);
    idle();                          checkOutput("enLowShift", 8'h20, 0, 1);
    load(8'h33);
    applyStimulus(1, 5, 0, 0, 0, 5, 1); checkOutput("abortStart", 8'h33, 1, 0);
    idle();                          checkOutput("abort1", 8'h66, 1, 0);
    idle();                          checkOutput("abort2", 8'hCC, 1, 0);
    resetPulse("abortReset");
    idle();                          checkOutput("abortNoDone1", 8'h00, 0, 0);
    idle();                          checkOutput("abortNoDone2", 8'h00, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 7),
                    $urandom_range(0, MASK), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 15), ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    repeat (3) @(posedge i_clk);
    #3;
    compare("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg_param.md
# universal_shift_reg_param

Parametrised successor to the 4-bit universal shift register. It is a WIDTH-bit register with the classic hold, shift-right, shift-left and parallel-load operations. It adds rotate, arithmetic shift right, synchronous clear, a clock enable, serial outputs, and a counted burst-shift engine with a busy/done handshake. It sits in the datapath wherever multi-step shifting is needed: serialisers, normalisers, barrel-shift substitutes.

## Interface
- WIDTH, 8, register width; minimum 2.
- CNT_W, 4, width of the burst shift count.

- i_clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; when low, the register and burst counter hold.
- mode  in  3  operation select (see Operation).
- in  in  WIDTH  parallel load data.
- sr  in  1  serial input for logical shift right; enters the MSB.
- sl  in  1  serial input for shift left; enters the LSB.
- amt  in  CNT_W  burst shift count, sampled with start.
- start  in  1  burst request.
- q_out  out  WIDTH  register contents.
- so_r  out  1  equals q_out[0], the bit the next right operation drops.
- so_l  out  1  equals q_out[WIDTH-1], the bit the next left operation drops.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after burst completion.

## Operation
- Mode encoding:
  - 000: hold.
  - 001: logical shift right, q <= {sr, q[W-1:1]}.
  - 010: shift left, q <= {q[W-2:0], sl}.
  - 011: parallel load, q <= in.
  - 100: rotate right.
  - 101: rotate left.
  - 110: arithmetic shift right; the MSB is replicated.
  - 111: synchronous clear, q <= 0.
- Shift modes are 001, 010, 100, 101 and 110.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - Each edge with en=1 applies mode directly.
  - If start=1 and mode is a shift mode, the mode is latched and the direct operation is suppressed on that edge.
  - If amt≠0: cnt <= amt, go to BURST.
  - If amt=0: go to DONE with q unchanged.
  - start with a non-shift mode is ignored as a burst; the mode executes directly.
  - start is honoured regardless of en.
- BURST:
  - Each edge with en=1 applies the latched mode once and decrements cnt.
  - On the edge where cnt goes 1→0, go to DONE.
  - Edges with en=0 hold q and cnt.
  - mode, in, amt and start are ignored.
  - sr and sl are sampled live on every shifting edge.
- DONE: lasts one cycle with done=1, then returns to IDLE. It behaves as IDLE, so a start or direct operation in this cycle is accepted.
- amt greater than WIDTH is legal:
  - Rotates wrap modulo WIDTH naturally.
  - Logical shifts fill fully with the serial input.
  - ASR saturates to all-sign.
- busy=1 exactly in BURST.
- so_r and so_l are combinational from q.

## Timing
- Reset (clr=0, asynchronous): q_out=0, so_r=0, so_l=0, busy=0, done=0, state=IDLE, cnt=0. Release is synchronous to the next edge.
- Direct operations have 1-cycle latency. The result is visible after the edge that samples mode with en=1.
- Burst:
  - Edge 0 samples start; busy rises after edge 0.
  - The shifts occur on the next amt enabled edges.
  - busy falls and done rises after the last shifting edge. done lasts exactly one cycle.
  - Minimum start-to-done is amt+1 cycles, plus one cycle per en=0 cycle during BURST.
- amt=0: done is high in the cycle after edge 0, and busy is never asserted.
- A start while busy=1 is dropped, with no queuing.
- clr asserted mid-burst aborts immediately: no done pulse, q=0.
- Simultaneous start and en=0 in IDLE: the burst is accepted and the first shift waits for en.

## Test plan
- Reset: drive clr=0 with q holding 0x5A. Required: q_out=0x00, busy=0 and done=0 asynchronously, before the next edge.
- Direct ops at WIDTH=8:
  - Load 0xA5.
  - Mode 001 with sr=1 → 0xD2.
  - Mode 010 with sl=0 → 0xA4.
  - Mode 000 → 0xA4 held.
  - Mode 111 → 0x00.
- Rotate burst: load 0x81, then start with mode=100, amt=3, en=1. Required: q_out steps 0xC0, 0x60, 0x30; busy high for 3 cycles; done high for 1 cycle immediately after; so_r=0 at the end.
- ASR burst: load 0x90, then start with mode=110, amt=2. Required: 0xC8 then 0xE4, then a done pulse.
- Stall: load 0x01, then start with mode=010, amt=4, sl=0. Hold en low for 2 cycles after the second shift. Required: final q_out=0x10; busy high for 6 cycles; done follows.
- Corner events:
  - start with amt=0: required done pulse on the next cycle, busy=0, q unchanged.
  - start during BURST: required to be ignored.
  - clr pulsed low during the second shift of an amt=5 burst: required q_out=0, busy=0, and no done pulse.
